nibbler_fetch: RTL and testbench
================================

Name: nibbler_fetch

Overview:
- Fetch/sequencer stage of the 4-bit CPU, directly upstream of the microcode decoder.
- Owns the 12-bit program counter and drives the program ROM address.
- Latches each instruction byte into the fetch register and generates the fetch/execute phase bit.
- Holds the C/Z flag register. Supplies opcode i[3:0], C, Z and phase to the decoder, and takes back the decoder's PC and flag controls.

Parameters:
- RESET_PC, 12'h000, PC value loaded on reset.
- HALT_DETECT, 1, 1 enables jump-to-self halt detection; 0 forces halted to 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low freezes all state (stall).
- prog_data  input  8  program ROM read data at prog_addr, combinational.
- load_pc  input  1  decoder control: load PC with jump target (sampled in execute only).
- inc_pc  input  1  decoder control: skip second instruction byte (sampled in execute only).
- load_flag  input  1  decoder control: capture ALU flags (sampled in execute only).
- c_in  input  1  ALU carry out.
- z_in  input  1  ALU zero out.
- prog_addr  output  12  program ROM address, equals PC register.
- instr  output  4  opcode, fetch register bits [7:4], to decoder i.
- operand  output  4  immediate/high address nibble, fetch register bits [3:0].
- phase  output  1  0 = fetch, 1 = execute.
- c_flag  output  1  registered carry flag, to decoder C.
- z_flag  output  1  registered zero flag, to decoder Z.
- halted  output  1  sticky jump-to-self indicator.

Behaviour:
- Reset, asynchronous, any time including mid-instruction: PC=RESET_PC, instr=0, operand=0, phase=0, c_flag=0, z_flag=0, halted=0.
- Two-state FSM on phase; it toggles on every clk edge with en=1.
- en=0: all registers hold, including phase. Controls are ignored.
- FETCH (phase=0), en=1:
  - {instr, operand} <= prog_data.
  - PC <= PC+1.
  - phase <= 1.
  - load_pc, inc_pc and load_flag are ignored.
- EXECUTE (phase=1), en=1, priority load_pc > inc_pc > hold:
  - load_pc=1: PC <= {operand, prog_data}. prog_data is the second instruction byte at PC.
  - else inc_pc=1: PC <= PC+1, skipping the address byte.
  - else: PC holds, for one-byte instructions.
  - load_flag=1: c_flag <= c_in, z_flag <= z_in. Otherwise flags hold.
  - The flag update is independent of the PC action, and both may occur in one cycle.
  - phase <= 0.
  - Fetch register holds through execute.
- PC arithmetic is 12-bit modulo: 12'hFFF+1 = 12'h000, in both fetch and execute increments.
- Latency: an opcode is visible on instr one cycle after its fetch edge, together with phase=1. A complete instruction takes 2 enabled cycles.
- Halt detect (HALT_DETECT=1):
  - Condition: an EXECUTE edge with load_pc=1 and target {operand, prog_data} == PC-1 (mod 4096), i.e. the jump lands on its own instruction address.
  - Effect: halted <= 1, sticky until reset. The CPU keeps running the loop.
- Controls held high during FETCH have no effect.
- A stall (en=0) in either phase resumes exactly where it left off.

Test Plan:
- Reset: assert reset mid-execute with PC=12'h345 -> immediately PC=000, phase=0, flags=0, halted=0. Release -> first fetch at address 000.
- Sequential one-byte instructions: ROM[0]=8'hA3, ROM[1]=8'h42, controls low -> instr=A/operand=3 at cycle 1, PC=1 after execute, then instr=4/operand=2, PC=2.
- Taken jump: ROM[0]=8'hC1, ROM[1]=8'h20, load_pc=1 in execute -> PC=12'h120 after 2 cycles. Not taken, inc_pc=1 -> PC=12'h002. Both high -> 12'h120.
- Flags: load_flag=1 with c_in=1, z_in=0 in execute -> c_flag=1, z_flag=0 next cycle. Same inputs during fetch -> flags unchanged.
- Wrap: PC=12'hFFF, fetch -> PC=000. Execute with inc_pc -> PC=001.
- Halt/stall:
  - ROM[12'h010]=8'hC0, ROM[12'h011]=8'h10, load_pc=1 -> halted=1, PC=12'h010. halted persists until reset.
  - en=0 for 3 cycles mid-execute -> phase, PC and flags frozen, then resume correctly.

Source files
------------

// File: rtl/nibbler_fetch_if.sv
// Fetch-stage bus of the 4-bit CPU: run enable, program ROM port, decoder controls/status.
// The master side is the fetch stage; the slave side is the ROM/decoder/ALU environment.
interface nibbler_fetch_if;
  logic        en;
  logic [7:0]  prog_data;
  logic        load_pc;
  logic        inc_pc;
  logic        load_flag;
  logic        c_in;
  logic        z_in;
  logic [11:0] prog_addr;
  logic [3:0]  instr;
  logic [3:0]  operand;
  logic        phase;
  logic        c_flag;
  logic        z_flag;
  logic        halted;

  modport master (
    input  en, prog_data, load_pc, inc_pc, load_flag, c_in, z_in,
    output prog_addr, instr, operand, phase, c_flag, z_flag, halted
  );

  modport slave (
    output en, prog_data, load_pc, inc_pc, load_flag, c_in, z_in,
    input  prog_addr, instr, operand, phase, c_flag, z_flag, halted
  );
endinterface

// File: rtl/nibbler_fetch.sv
// Fetch/sequencer stage: program counter, fetch register, fetch/execute phase,
// C/Z flag register and sticky jump-to-self halt detection.
module nibbler_fetch #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter bit          HALT_DETECT = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  nibbler_fetch_if.master bus
);

  localparam int unsigned PC_W = 12;
  localparam int unsigned IR_W = 8;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_t;

  phase_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            c_q, c_d, z_q, z_d;
  logic            halt_q, halt_d;

  // Phase state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Phase toggles on every enabled edge
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        FETCH:   state_d = EXEC;
        default: state_d = FETCH;
      endcase
    end
  end

  // Datapath next values; decoder controls only matter in execute
  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    c_d    = c_q;
    z_d    = z_q;
    halt_d = halt_q;
    target = {ir_q[3:0], bus.prog_data};
    if (bus.en) begin
      case (state_q)
        FETCH: begin
          ir_d = bus.prog_data;
          pc_d = pc_q + PC_W'(1);
        end
        default: begin
          if (bus.load_pc) begin
            pc_d = target;
            // pc_q already points past the opcode byte, so self-jump targets pc_q-1
            if (HALT_DETECT && (target == pc_q - PC_W'(1))) halt_d = 1'b1;
          end else if (bus.inc_pc) begin
            pc_d = pc_q + PC_W'(1);
          end
          if (bus.load_flag) begin
            c_d = bus.c_in;
            z_d = bus.z_in;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      ir_q   <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      c_q    <= c_d;
      z_q    <= z_d;
      halt_q <= halt_d;
    end
  end

  assign bus.prog_addr = pc_q;
  assign bus.instr     = ir_q[7:4];
  assign bus.operand   = ir_q[3:0];
  assign bus.phase     = state_q;
  assign bus.c_flag    = c_q;
  assign bus.z_flag    = z_q;
  assign bus.halted    = halt_q;

endmodule

// File: tb/tb_nibbler_fetch.sv
// Directed bench for nibbler_fetch: hand-computed expectations checked with immediate assertions.
module tb_nibbler_fetch;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] rom [0:4095];
  int total = 0;
  int bad = 0;

  nibbler_fetch_if bus ();

  nibbler_fetch #(.RESET_PC(12'h000), .HALT_DETECT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.prog_data = rom[bus.prog_addr];

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.en = 1'b0;
    bus.load_pc = 1'b0;
    bus.inc_pc = 1'b0;
    bus.load_flag = 1'b0;
    bus.c_in = 1'b0;
    bus.z_in = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'hA3;
    rom[12'h001] = 8'h42;
    rom[12'h002] = 8'hC1;
    rom[12'h003] = 8'h20;
    rom[12'h120] = 8'hB5;
    rom[12'h122] = 8'h93;
    rom[12'h123] = 8'h44;
    rom[12'h344] = 8'h00;

    // reset state
    tick(); tick();
    chk("rst_pc", bus.prog_addr, 12'h000);
    chk("rst_phase", 12'(bus.phase), 12'h0);
    chk("rst_instr", 12'(bus.instr), 12'h0);
    chk("rst_operand", 12'(bus.operand), 12'h0);
    chk("rst_c", 12'(bus.c_flag), 12'h0);
    chk("rst_z", 12'(bus.z_flag), 12'h0);
    chk("rst_halted", 12'(bus.halted), 12'h0);

    // sequential one-byte instructions
    reset = 1'b0;
    bus.en = 1'b1;
    tick();
    chk("seq0_instr", 12'(bus.instr), 12'hA);
    chk("seq0_operand", 12'(bus.operand), 12'h3);
    chk("seq0_phase", 12'(bus.phase), 12'h1);
    chk("seq0_pc", bus.prog_addr, 12'h001);
    tick();
    chk("seq0_exec_pc", bus.prog_addr, 12'h001);
    chk("seq0_exec_phase", 12'(bus.phase), 12'h0);
    chk("seq0_ir_hold", 12'(bus.instr), 12'hA);
    tick();
    chk("seq1_instr", 12'(bus.instr), 12'h4);
    chk("seq1_operand", 12'(bus.operand), 12'h2);
    chk("seq1_pc", bus.prog_addr, 12'h002);
    tick();
    chk("seq1_exec_pc", bus.prog_addr, 12'h002);

    // controls high during fetch are ignored
    bus.load_pc = 1'b1;
    bus.inc_pc = 1'b1;
    bus.load_flag = 1'b1;
    bus.c_in = 1'b1;
    bus.z_in = 1'b1;
    tick();
    chk("fetch_ctl_pc", bus.prog_addr, 12'h003);
    chk("fetch_ctl_c", 12'(bus.c_flag), 12'h0);
    chk("fetch_ctl_z", 12'(bus.z_flag), 12'h0);
    chk("jmp_instr", 12'(bus.instr), 12'hC);

    // taken jump with inc_pc also high, plus flag load
    bus.z_in = 1'b0;
    tick();
    chk("jmp_pc", bus.prog_addr, 12'h120);
    chk("jmp_c", 12'(bus.c_flag), 12'h1);
    chk("jmp_z", 12'(bus.z_flag), 12'h0);
    chk("jmp_halted", 12'(bus.halted), 12'h0);

    // not taken, skip address byte; flags hold
    bus.load_pc = 1'b0;
    bus.inc_pc = 1'b0;
    bus.load_flag = 1'b0;
    tick();
    chk("skip_fetch_pc", bus.prog_addr, 12'h121);
    chk("skip_instr", 12'(bus.instr), 12'hB);
    bus.inc_pc = 1'b1;
    bus.c_in = 1'b0;
    bus.z_in = 1'b1;
    tick();
    chk("skip_pc", bus.prog_addr, 12'h122);
    chk("skip_c_hold", 12'(bus.c_flag), 12'h1);
    chk("skip_z_hold", 12'(bus.z_flag), 12'h0);

    // jump to 344, fetch there, then reset mid-execute at PC=345
    bus.inc_pc = 1'b0;
    tick();
    bus.load_pc = 1'b1;
    tick();
    chk("jmp2_pc", bus.prog_addr, 12'h344);
    bus.load_pc = 1'b0;
    tick();
    chk("mid_pc", bus.prog_addr, 12'h345);
    chk("mid_phase", 12'(bus.phase), 12'h1);
    reset = 1'b1;
    #1;
    chk("async_pc", bus.prog_addr, 12'h000);
    chk("async_phase", 12'(bus.phase), 12'h0);
    chk("async_c", 12'(bus.c_flag), 12'h0);
    chk("async_instr", 12'(bus.instr), 12'h0);
    chk("async_halted", 12'(bus.halted), 12'h0);
    #2;
    reset = 1'b0;

    // wrap: jump to FFF, fetch wraps to 000, execute inc to 001
    rom[12'h000] = 8'hCF;
    rom[12'h001] = 8'hFF;
    rom[12'hFFF] = 8'h71;
    tick();
    chk("post_rst_fetch_pc", bus.prog_addr, 12'h001);
    chk("post_rst_instr", 12'(bus.instr), 12'hC);
    bus.load_pc = 1'b1;
    tick();
    chk("wrap_jmp_pc", bus.prog_addr, 12'hFFF);
    bus.load_pc = 1'b0;
    tick();
    chk("wrap_fetch_pc", bus.prog_addr, 12'h000);
    chk("wrap_instr", 12'(bus.instr), 12'h7);
    chk("wrap_operand", 12'(bus.operand), 12'h1);
    bus.inc_pc = 1'b1;
    bus.load_flag = 1'b1;
    bus.c_in = 1'b0;
    bus.z_in = 1'b1;
    tick();
    chk("wrap_inc_pc", bus.prog_addr, 12'h001);
    chk("wrap_c", 12'(bus.c_flag), 12'h0);
    chk("wrap_z", 12'(bus.z_flag), 12'h1);
    bus.inc_pc = 1'b0;
    bus.load_flag = 1'b0;

    // jump-to-self halt at 010
    rom[12'h001] = 8'hC0;
    rom[12'h002] = 8'h10;
    rom[12'h010] = 8'hC0;
    rom[12'h011] = 8'h10;
    tick();
    chk("h_fetch_pc", bus.prog_addr, 12'h002);
    bus.load_pc = 1'b1;
    tick();
    chk("h_jmp_pc", bus.prog_addr, 12'h010);
    chk("h_not_yet", 12'(bus.halted), 12'h0);
    bus.load_pc = 1'b0;
    tick();
    chk("h_loop_fetch_pc", bus.prog_addr, 12'h011);
    bus.load_pc = 1'b1;
    tick();
    chk("halt_pc", bus.prog_addr, 12'h010);
    chk("halt_set", 12'(bus.halted), 12'h1);

    // stall mid-execute for 3 cycles with controls asserted
    bus.load_pc = 1'b0;
    tick();
    chk("st_pc_pre", bus.prog_addr, 12'h011);
    bus.en = 1'b0;
    bus.load_pc = 1'b1;
    bus.inc_pc = 1'b1;
    bus.load_flag = 1'b1;
    bus.c_in = 1'b1;
    bus.z_in = 1'b0;
    tick(); tick(); tick();
    chk("st_phase", 12'(bus.phase), 12'h1);
    chk("st_pc", bus.prog_addr, 12'h011);
    chk("st_c", 12'(bus.c_flag), 12'h0);
    chk("st_z", 12'(bus.z_flag), 12'h1);
    chk("st_instr", 12'(bus.instr), 12'hC);
    bus.en = 1'b1;
    tick();
    chk("resume_pc", bus.prog_addr, 12'h010);
    chk("resume_phase", 12'(bus.phase), 12'h0);
    chk("resume_c", 12'(bus.c_flag), 12'h1);
    chk("resume_z", 12'(bus.z_flag), 12'h0);
    chk("halt_sticky", 12'(bus.halted), 12'h1);
    bus.load_pc = 1'b0;
    bus.inc_pc = 1'b0;
    bus.load_flag = 1'b0;
    tick();
    chk("halt_sticky2", 12'(bus.halted), 12'h1);
    chk("resume_fetch_pc", bus.prog_addr, 12'h011);
    reset = 1'b1;
    #1;
    chk("halt_cleared", 12'(bus.halted), 12'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
